// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared RNS constants, default moduli and converter state encoding
package rns_pkg;

    localparam int MOD_NUM  = 4;
    localparam int MOD_SIZE = 3;
    localparam int MOD_W    = MOD_SIZE + 1;
    localparam int RANGE    = MOD_NUM * MOD_SIZE;
    localparam int CNT_W    = $clog2(RANGE + 1);
    localparam int MAX_MOD  = 1 << MOD_SIZE;

    localparam logic [MOD_W-1:0] DEF_MOD_1 = MOD_W'(7);
    localparam logic [MOD_W-1:0] DEF_MOD_2 = MOD_W'(5);
    localparam logic [MOD_W-1:0] DEF_MOD_3 = MOD_W'(3);
    localparam logic [MOD_W-1:0] DEF_MOD_4 = MOD_W'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rns_horner_lane.sv
// rtl/rns_horner_lane.sv - one modulus lane of the bit-serial Horner residue reduction
module rns_horner_lane
    import rns_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                step_en,
    input  logic                step_bit,
    input  logic                fix_en,
    input  logic                fix_sign,
    input  logic [MOD_W-1:0]    modulus,
    output logic [MOD_SIZE-1:0] residue,
    output logic                illegal
);

    logic [MOD_SIZE-1:0] r;
    logic [MOD_W-1:0]    t;
    logic [MOD_SIZE-1:0] step_next;
    logic [MOD_SIZE-1:0] fixed;

    assign illegal = (modulus < MOD_W'(2)) || (modulus > MOD_W'(MAX_MOD));

    // t = 2*r + bit; since r < m, t < 2*m and a single subtract brings it back into range
    assign t = {r, step_bit};

    // Next residue for a Horner step, and the sign/legality fix-up of the finished residue.
    // The subtraction is done in MOD_SIZE bits: the true result is below m <= 2^MOD_SIZE,
    // so wrapping modulo 2^MOD_SIZE gives the exact value (m = 2^MOD_SIZE included).
    always_comb begin
        step_next = t[MOD_SIZE-1:0];
        if (t >= modulus) begin
            step_next = t[MOD_SIZE-1:0] - modulus[MOD_SIZE-1:0];
        end
        fixed = r;
        if (illegal) begin
            fixed = '0;
        end else if (fix_sign && (r != '0)) begin
            fixed = modulus[MOD_SIZE-1:0] - r;
        end
    end

    // During the fix cycle the parent samples the fixed-up value in the same edge it is stored
    assign residue = fix_en ? fixed : r;

    // Residue register: cleared on accept, stepped once per input bit, fixed up once at the end
    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (step_en) begin
            r <= step_next;
        end else if (fix_en) begin
            r <= fixed;
        end
    end

endmodule

// File: rtl/bin2rns_seq.sv
// rtl/bin2rns_seq.sv - sequential signed binary to four-residue RNS forward converter
module bin2rns_seq
    import rns_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [MOD_W-1:0]    mod_1,
    input  logic [MOD_W-1:0]    mod_2,
    input  logic [MOD_W-1:0]    mod_3,
    input  logic [MOD_W-1:0]    mod_4,
    input  logic [RANGE-1:0]    x_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MOD_SIZE-1:0] c0,
    output logic [MOD_SIZE-1:0] c1,
    output logic [MOD_SIZE-1:0] c2,
    output logic [MOD_SIZE-1:0] c3,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [RANGE-1:0]    mag;
    logic                sign;
    logic [MOD_W-1:0]    mod_q    [MOD_NUM];
    logic [MOD_SIZE-1:0] lane_res [MOD_NUM];
    logic [MOD_NUM-1:0]  lane_ill;
    logic                accept;

    assign accept = (state == IDLE) && in_valid && in_ready;

    for (genvar k = 0; k < MOD_NUM; k++) begin : g_lane
        rns_horner_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (accept),
            .step_en  (state == RUN),
            .step_bit (mag[RANGE-1]),
            .fix_en   (state == FIX),
            .fix_sign (sign),
            .modulus  (mod_q[k]),
            .residue  (lane_res[k]),
            .illegal  (lane_ill[k])
        );
    end

    // Control FSM: latch operands, feed magnitude MSB-first, publish residues, hold until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            c0        <= '0;
            c1        <= '0;
            c2        <= '0;
            c3        <= '0;
            cnt       <= '0;
            mag       <= '0;
            sign      <= 1'b0;
            mod_q[0]  <= DEF_MOD_1;
            mod_q[1]  <= DEF_MOD_2;
            mod_q[2]  <= DEF_MOD_3;
            mod_q[3]  <= DEF_MOD_4;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mod_q[0] <= mod_1;
                        mod_q[1] <= mod_2;
                        mod_q[2] <= mod_3;
                        mod_q[3] <= mod_4;
                        sign     <= x_in[RANGE-1];
                        // Two's-complement negate; the most negative word maps onto 2^(RANGE-1)
                        mag      <= x_in[RANGE-1] ? (~x_in + RANGE'(1)) : x_in;
                        cnt      <= CNT_W'(RANGE);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    mag <= mag << 1;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    c0        <= lane_res[0];
                    c1        <= lane_res[1];
                    c2        <= lane_res[2];
                    c3        <= lane_res[3];
                    out_err   <= |lane_ill;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2rns_seq.sv
// tb/tb_bin2rns_seq.sv - randomized and directed self-checking bench for bin2rns_seq
module tb_bin2rns_seq;
    import rns_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [MOD_W-1:0]    mod_1 = '0, mod_2 = '0, mod_3 = '0, mod_4 = '0;
    logic [RANGE-1:0]    x_in = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [MOD_SIZE-1:0] c0, c1, c2, c3;
    logic                out_err;
    logic                out_valid;
    logic                out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int exp_c [4];
    int exp_err;
    int accept_wait;

    bin2rns_seq dut (
        .clk       (clk),
        .reset     (reset),
        .mod_1     (mod_1),
        .mod_2     (mod_2),
        .mod_3     (mod_3),
        .mod_4     (mod_4),
        .x_in      (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Mathematical residue in 0..m-1; lanes with an out-of-range modulus read 0
    function automatic int ref_res(input int x, input int m);
        if (m < 2 || m > MAX_MOD) return 0;
        return ((x % m) + m) % m;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, " c0"}, 32'(c0), 32'(exp_c[0]));
        chk({tag, " c1"}, 32'(c1), 32'(exp_c[1]));
        chk({tag, " c2"}, 32'(c2), 32'(exp_c[2]));
        chk({tag, " c3"}, 32'(c3), 32'(exp_c[3]));
        chk({tag, " err"}, 32'(out_err), 32'(exp_err));
    endtask

    // One full conversion; called at a negedge, returns at the negedge where out_valid is first seen
    // (or one cycle later if drain is set and out_ready was high).
    task automatic convert(input string tag, input int x, input int m1, input int m2,
                           input int m3, input int m4, input bit scramble, input bit drain);
        int lat;
        int ms [4];
        ms = '{m1, m2, m3, m4};
        x_in = RANGE'(x);
        mod_1 = MOD_W'(m1); mod_2 = MOD_W'(m2); mod_3 = MOD_W'(m3); mod_4 = MOD_W'(m4);
        in_valid = 1'b1;
        accept_wait = 0;
        while (!in_ready && accept_wait < 50) begin
            @(negedge clk);
            accept_wait++;
        end
        if (!in_ready) chk({tag, " accept timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            x_in = RANGE'($urandom);
            mod_1 = MOD_W'($urandom); mod_2 = MOD_W'($urandom);
            mod_3 = MOD_W'($urandom); mod_4 = MOD_W'($urandom);
            in_valid = 1'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        exp_err = 0;
        for (int k = 0; k < 4; k++) begin
            exp_c[k] = ref_res(x, ms[k]);
            if (ms[k] < 2 || ms[k] > MAX_MOD) exp_err = 1;
        end
        chk({tag, " latency"}, 32'(lat), 32'd13);
        check_outputs(tag);
        if (drain && out_ready) @(negedge clk);
    endtask

    initial begin
        int hold_bad;
        int spurious;
        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset c0..c3", {20'd0, c0, c1, c2, c3}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed values with default moduli 7,5,3,8
        convert("x=100", 100, 7, 5, 3, 8, 1'b0, 1'b1);
        convert("x=-1", -1, 7, 5, 3, 8, 1'b1, 1'b1);
        convert("x=0", 0, 7, 5, 3, 8, 1'b0, 1'b1);
        convert("x=-420", -420, 7, 5, 3, 8, 1'b1, 1'b1);
        convert("x=2047", 2047, 7, 5, 3, 8, 1'b1, 1'b1);
        convert("x=-2048", -2048, 7, 5, 3, 8, 1'b1, 1'b1);

        // Backpressure: hold out_ready low for 20 cycles after out_valid
        out_ready = 1'b0;
        convert("bp", -77, 7, 5, 3, 8, 1'b1, 1'b0);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || c0 != 3'(exp_c[0]) || c1 != 3'(exp_c[1]) ||
                c2 != 3'(exp_c[2]) || c3 != 3'(exp_c[3]) || out_err != 1'(exp_err))
                hold_bad++;
        end
        chk("bp hold stable cycles bad", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        convert("bp next", 555, 7, 5, 3, 8, 1'b0, 1'b1);
        chk("bp next accept wait", 32'(accept_wait), 32'd0);

        // Reset asserted five cycles into RUN aborts the conversion
        x_in = RANGE'(300);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort c0..c3", {20'd0, c0, c1, c2, c3}, 32'd0);
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("abort no output", 32'(spurious), 32'd0);
        convert("after abort x=100", 100, 7, 5, 3, 8, 1'b0, 1'b1);

        // Illegal moduli
        convert("mod_2=1", 100, 7, 1, 3, 8, 1'b0, 1'b1);
        convert("mod_1=0", -37, 0, 5, 3, 8, 1'b1, 1'b1);
        convert("mod_4=9", 1234, 7, 5, 3, 9, 1'b1, 1'b1);
        convert("mod_3=15", -999, 2, 8, 15, 4, 1'b1, 1'b1);

        // Exhaustive sweep over -420..419 with default moduli
        for (int x = -420; x <= 419; x++) begin
            convert($sformatf("sweep x=%0d", x), x, 7, 5, 3, 8, 1'b1, 1'b1);
        end

        // Random full-range values with random legal moduli
        for (int i = 0; i < 150; i++) begin
            int xr;
            int m [4];
            xr = int'($urandom_range(0, 4095)) - 2048;
            for (int k = 0; k < 4; k++) m[k] = int'($urandom_range(2, MAX_MOD));
            convert($sformatf("rand x=%0d m=%0d,%0d,%0d,%0d", xr, m[0], m[1], m[2], m[3]),
                    xr, m[0], m[1], m[2], m[3], 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
